// File: rtl/bram_lane_accessor.sv
// Multi-lane BRAM streaming engine: reads N packed words from BRAM0, applies a
// per-lane unsigned op and writes double-width packed results to BRAM1.

module bram_lane_op #(
  parameter int W = 8
) (
  input  logic [1:0]     mode_i,
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   coef_i,
  output logic [2*W-1:0] y_o
);
  logic [2*W-1:0] x_ext, c_ext;
  logic [W:0]     sum;

  assign x_ext = {{W{1'b0}}, x_i};
  assign c_ext = {{W{1'b0}}, coef_i};
  assign sum   = {1'b0, x_i} + {1'b0, coef_i};

  always_comb begin
    y_o = '0;
    case (mode_i)
      2'd0:    y_o = x_ext * x_ext;
      2'd1:    y_o = x_ext;
      2'd2:    y_o = x_ext * c_ext;
      default: y_o = {{(W-1){1'b0}}, sum};
    endcase
  end
endmodule

module bram_lane_accessor #(
  parameter int NUM_LANES     = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 8,
  parameter int CNT_BIT       = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start_run_i,
  input  logic [CNT_BIT-1:0]                run_count_i,
  input  logic [1:0]                        mode_i,
  input  logic [IN_DATA_WIDTH-1:0]          coef_i,
  input  logic [AWIDTH-1:0]                 src_base_i,
  input  logic [AWIDTH-1:0]                 dst_base_i,
  input  logic [NUM_LANES*IN_DATA_WIDTH-1:0] q_b0_i,
  output logic                              idle_o,
  output logic                              read_o,
  output logic                              write_o,
  output logic                              done_o,
  output logic [AWIDTH-1:0]                 addr_b0_o,
  output logic                              ce_b0_o,
  output logic                              we_b0_o,
  output logic [AWIDTH-1:0]                 addr_b1_o,
  output logic                              ce_b1_o,
  output logic                              we_b1_o,
  output logic [NUM_LANES*2*IN_DATA_WIDTH-1:0] d_b1_o
);
  localparam int W        = IN_DATA_WIDTH;
  localparam int DWIDTH_1 = NUM_LANES * W;
  localparam int DWIDTH_2 = NUM_LANES * 2 * W;
  // stage 0: BRAM0 data on q_b0_i, stage 1: lane results registered / write
  localparam int STAGES   = 1;
  localparam logic [CNT_BIT-1:0] CNT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [CNT_BIT-1:0] cnt;
    logic [1:0]         mode;
    logic [W-1:0]       coef;
    logic [AWIDTH-1:0]  src;
    logic [AWIDTH-1:0]  dst;
  } cfg_t;

  state_t                         state_q, state_d;
  cfg_t                           cfg_q, cfg_d;
  logic [CNT_BIT-1:0]             rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [STAGES:0]                vld_pipe;
  logic [NUM_LANES-1:0][W-1:0]    x_lanes;
  logic [NUM_LANES-1:0][2*W-1:0]  res_d, res_q;
  logic                           rd_en, wr_en;

  // Packed-array index NUM_LANES-1 is the MSB slot, i.e. ordinal lane 0.
  assign x_lanes = q_b0_i;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bram_lane_op #(.W(W)) u_op (
      .mode_i (cfg_q.mode),
      .x_i    (x_lanes[i]),
      .coef_i (cfg_q.coef),
      .y_o    (res_d[i])
    );
  end

  assign rd_en = (state_q == S_RUN) && (rd_cnt_q < cfg_q.cnt);
  assign wr_en = vld_pipe[STAGES];

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      S_IDLE: if (start_run_i) begin
        cfg_d    = '{cnt: run_count_i, mode: mode_i, coef: coef_i,
                     src: src_base_i, dst: dst_base_i};
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        state_d  = (run_count_i == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rd_en) rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (wr_en) begin
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (wr_cnt_q == cfg_q.cnt - CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      vld_pipe <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
      if (vld_pipe[0]) res_q <= res_d;
    end
  end

  assign idle_o    = (state_q == S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign read_o    = rd_en;
  assign ce_b0_o   = rd_en;
  assign we_b0_o   = 1'b0;
  assign addr_b0_o = rd_en ? cfg_q.src + rd_cnt_q[AWIDTH-1:0] : '0;
  assign write_o   = wr_en;
  assign ce_b1_o   = wr_en;
  assign we_b1_o   = wr_en;
  assign addr_b1_o = wr_en ? cfg_q.dst + wr_cnt_q[AWIDTH-1:0] : '0;
  assign d_b1_o    = wr_en ? DWIDTH_2'(res_q) : '0;

  logic unused_w;
  assign unused_w = ^{DWIDTH_1'(0)};
endmodule

// File: tb/tb_bram_lane_accessor.sv
// Bench for bram_lane_accessor: BRAM models, vector table, scoreboard of writes.

module tb_bram_lane_accessor;
  localparam int NL = 4, W = 8, AW = 8, CB = 16;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          start_run_i = 1'b0;
  logic [CB-1:0] run_count_i = '0;
  logic [1:0]    mode_i = '0;
  logic [W-1:0]  coef_i = '0;
  logic [AW-1:0] src_base_i = '0, dst_base_i = '0;
  logic [31:0]   q_b0_i = '0;
  logic          idle_o, read_o, write_o, done_o, ce_b0_o, we_b0_o, ce_b1_o, we_b1_o;
  logic [AW-1:0] addr_b0_o, addr_b1_o;
  logic [63:0]   d_b1_o;

  bram_lane_accessor #(.NUM_LANES(NL), .IN_DATA_WIDTH(W), .AWIDTH(AW), .CNT_BIT(CB)) dut (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .mode_i(mode_i), .coef_i(coef_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .q_b0_i(q_b0_i), .idle_o(idle_o), .read_o(read_o), .write_o(write_o), .done_o(done_o),
    .addr_b0_o(addr_b0_o), .ce_b0_o(ce_b0_o), .we_b0_o(we_b0_o), .addr_b1_o(addr_b1_o),
    .ce_b1_o(ce_b1_o), .we_b1_o(we_b1_o), .d_b1_o(d_b1_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [63:0] d; } wr_t;
  typedef struct { int c; logic [7:0] a; } rd_t;
  typedef struct { logic [1:0] mode; logic [7:0] coef; logic [31:0] word; logic [63:0] exp; } vec_t;

  logic [31:0] bram0 [256];
  logic [63:0] bram1 [256];
  wr_t  sb[$];
  rd_t  rd_log[$];
  int   wr_log[$];
  int   done_log[$];
  int   cyc = 0;
  int   total = 0, bad = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce_b0_o) q_b0_i <= bram0[addr_b0_o];
    if (ce_b1_o && we_b1_o) bram1[addr_b1_o] <= d_b1_o;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [87:0] outs();
    return {idle_o, read_o, write_o, done_o, addr_b0_o, ce_b0_o, we_b0_o,
            addr_b1_o, ce_b1_o, we_b1_o, d_b1_o};
  endfunction

  function automatic logic [63:0] model(input logic [31:0] w, input logic [1:0] m, input logic [7:0] c);
    logic [63:0] r;
    logic [7:0]  x;
    logic [15:0] y;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      x = w[31-8*k -: 8];
      case (m)
        2'd0:    y = {8'h0, x} * {8'h0, x};
        2'd1:    y = {8'h0, x};
        2'd2:    y = {8'h0, x} * {8'h0, c};
        default: y = {8'h0, x} + {8'h0, c};
      endcase
      r[63-16*k -: 16] = y;
    end
    return r;
  endfunction

  // Scoreboard check on every observed BRAM1 access; logs for timing checks.
  always @(negedge clk) begin
    wr_t e;
    if (ce_b0_o || read_o) begin
      rd_log.push_back('{cyc, addr_b0_o});
      chk("rd_strobes", {ce_b0_o, read_o, we_b0_o}, 3'b110);
    end
    if (ce_b1_o || we_b1_o || write_o) begin
      wr_log.push_back(cyc);
      chk("wr_strobes", {ce_b1_o, we_b1_o, write_o}, 3'b111);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write actual=%0h required=none (cycle %0d)", addr_b1_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", addr_b1_o, e.a);
        chk("wr_data", d_b1_o, e.d);
      end
    end
    if (done_o) done_log.push_back(cyc);
  end

  task automatic push_model(input int n, input logic [1:0] m, input logic [7:0] c,
                            input logic [7:0] src, input logic [7:0] dst);
    for (int k = 0; k < n; k++)
      sb.push_back('{8'(dst + 8'(k)), model(bram0[8'(src + 8'(k))], m, c)});
  endtask

  task automatic do_run(input int n, input logic [1:0] m, input logic [7:0] c,
                        input logic [7:0] src, input logic [7:0] dst, input bit restart);
    int s, exp_done, exp_idle;
    rd_log.delete(); wr_log.delete(); done_log.delete();
    @(negedge clk);
    start_run_i = 1'b1; run_count_i = CB'(n); mode_i = m; coef_i = c;
    src_base_i = src; dst_base_i = dst;
    s = cyc;
    exp_done = (n == 0) ? s + 1 : s + n + 3;
    exp_idle = exp_done + 1;
    while (cyc < exp_idle + 1) begin
      @(negedge clk);
      if (cyc == s + 1) begin
        start_run_i = 1'b0; mode_i = 2'($urandom); coef_i = 8'($urandom);
        src_base_i = 8'($urandom); dst_base_i = 8'($urandom); run_count_i = 16'($urandom);
      end
      if (restart && cyc == s + 2) begin start_run_i = 1'b1; run_count_i = 16'd9; end
      if (restart && cyc == s + 3) start_run_i = 1'b0;
      if (cyc == exp_done) chk("idle_low_in_done", idle_o, 1'b0);
      if (cyc == exp_idle) chk("idle_back", idle_o, 1'b1);
    end
    chk("done_pulses", done_log.size(), 1);
    if (done_log.size() > 0) chk("done_cycle", done_log[0], exp_done);
    chk("read_count", rd_log.size(), n);
    for (int k = 0; k < n && k < rd_log.size(); k++) begin
      chk("read_cycle", rd_log[k].c, s + 1 + k);
      chk("read_addr", rd_log[k].a, 8'(src + 8'(k)));
    end
    chk("write_count", wr_log.size(), n);
    if (n > 0 && wr_log.size() == n) begin
      chk("first_write_cycle", wr_log[0], s + 3);
      chk("last_write_cycle", wr_log[n-1], s + n + 2);
    end
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  vec_t vt [7];

  initial begin
    vt[0] = '{2'd0, 8'h00, 32'h01030507, 64'h0001000900190031};
    vt[1] = '{2'd2, 8'h03, 32'hFF102001, 64'h02FD003000600003};
    vt[2] = '{2'd3, 8'h01, 32'hFF000102, 64'h0100000100020003};
    vt[3] = '{2'd1, 8'h5A, 32'h000000AB, 64'h00000000000000AB};
    vt[4] = '{2'd0, 8'h00, 32'hFFFFFFFF, 64'hFE01FE01FE01FE01};
    vt[5] = '{2'd2, 8'hFF, 32'h000000FF, 64'h000000000000FE01};
    vt[6] = '{2'd3, 8'hFF, 32'hFFFFFFFF, 64'h01FE01FE01FE01FE};
    for (int i = 0; i < 256; i++) begin bram0[i] = $urandom; bram1[i] = '0; end

    #1 chk("reset_outputs", outs(), {1'b1, 87'h0});
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Mode 0 basic run with timing checks.
    bram0[0] = 32'h01030507;
    push_model(4, 2'd0, 8'h00, 8'h00, 8'h00);
    do_run(4, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("bram1_0", bram1[0], 64'h0001000900190031);

    // Single-word vector table; expected values are hand-derived constants.
    for (int i = 0; i < 7; i++) begin
      bram0[8'h20 + i] = vt[i].word;
      sb.push_back('{8'(8'h40 + i), vt[i].exp});
      do_run(1, vt[i].mode, vt[i].coef, 8'(8'h20 + i), 8'(8'h40 + i), 1'b0);
      chk("vec_bram1", bram1[8'h40 + i], vt[i].exp);
    end

    // Zero count: done only, no memory strobes.
    do_run(0, 2'd1, 8'h00, 8'h10, 8'h10, 1'b0);

    // Address wrap plus an ignored second start during RUN.
    push_model(4, 2'd3, 8'h07, 8'hFE, 8'hFF);
    do_run(4, 2'd3, 8'h07, 8'hFE, 8'hFF, 1'b1);

    // Longer run in mode 2 with inputs scrambled after acceptance.
    push_model(12, 2'd2, 8'hC3, 8'h30, 8'h90);
    do_run(12, 2'd2, 8'hC3, 8'h30, 8'h90, 1'b0);

    // Reset mid-run after two writes of an 8-word run.
    push_model(8, 2'd2, 8'h05, 8'h10, 8'h80);
    rd_log.delete(); wr_log.delete(); done_log.delete();
    @(negedge clk);
    start_run_i = 1'b1; run_count_i = 16'd8; mode_i = 2'd2; coef_i = 8'h05;
    src_base_i = 8'h10; dst_base_i = 8'h80;
    @(negedge clk);
    start_run_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (wr_log.size() >= 2) break;
    end
    chk("two_writes_before_reset", wr_log.size(), 2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 chk("midrun_reset_outputs", outs(), {1'b1, 87'h0});
    repeat (4) @(negedge clk);
    chk("no_writes_in_reset", wr_log.size(), 2);
    chk("no_done_in_reset", done_log.size(), 0);
    sb.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_done_after_reset", done_log.size(), 0);

    push_model(5, 2'd0, 8'h00, 8'h50, 8'hA0);
    do_run(5, 2'd0, 8'h00, 8'h50, 8'hA0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
